// File: rtl/adc_sar_controller.sv
// 12-bit SAR ADC sequencer: sample, per-bit settle/strobe/decide, and a result with a one-cycle valid pulse.
// Optional build macro ADC_SAR_AVG_EN: averages 2^AVG_LOG2 back-to-back conversions per start.
module adc_sar_controller #(
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int AVG_LOG2      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_conv_in,
  input  logic        abort_in,
  input  logic        comp_in,
  output logic [11:0] dac_code_out,
  output logic        sample_out,
  output logic        comp_en_out,
  output logic        busy_out,
  output logic [11:0] result_out,
  output logic        valid_out
);

  if (SAMPLE_CYCLES < 1 || SETTLE_CYCLES < 1 || AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_param_check
    $error("adc_sar_controller: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_SETTLE,
    S_STROBE,
    S_DECIDE,
    S_DONE
  } state_e;

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         bit_idx_q;
  logic [11:0]        dac_q;
  logic               sample_q;
  logic               comp_en_q;
  logic               busy_q;
  logic [11:0]        result_q;
  logic               valid_q;

  logic               start_ok_d;
  logic               abort_ok_d;
  logic               comp_keep_d;
  logic [11:0]        bit_mask_d;
  logic [11:0]        code_d;
  logic               conv_last_d;
  logic [11:0]        result_d;

  // Gating with the state keeps an undriven comparator out of the datapath.
  assign comp_keep_d = (state_q == S_DECIDE) & comp_in;
  assign start_ok_d  = (state_q == S_IDLE) & start_conv_in & ~abort_in;
  assign abort_ok_d  = (state_q != S_IDLE) & abort_in;

  // NOTE: always_comb assigns every output before any branch so no latch is inferred.
  always_comb begin
    bit_mask_d = 12'h001 << bit_idx_q;
    code_d     = comp_keep_d ? dac_q : (dac_q & ~bit_mask_d);
  end

`ifdef ADC_SAR_AVG_EN
  localparam int NUM_CONV = 1 << AVG_LOG2;
  localparam int ACC_W    = 12 + AVG_LOG2;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [4:0]       conv_q;

  assign acc_d       = acc_q + ACC_W'(code_d);
  assign conv_last_d = (conv_q == 5'(NUM_CONV - 1));
  assign result_d    = acc_d[AVG_LOG2 +: 12];

  always_ff @(posedge clk) begin
    if (rst || abort_ok_d || start_ok_d) begin
      acc_q  <= '0;
      conv_q <= '0;
    end else if (state_q == S_DECIDE && bit_idx_q == 4'd0) begin
      acc_q  <= acc_d;
      conv_q <= conv_q + 5'd1;
    end
  end
`else
  assign conv_last_d = 1'b1;
  assign result_d    = code_d;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 4'd11;
      dac_q     <= '0;
      sample_q  <= 1'b0;
      comp_en_q <= 1'b0;
      busy_q    <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else if (abort_ok_d) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 4'd11;
      dac_q     <= '0;
      sample_q  <= 1'b0;
      comp_en_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          valid_q <= 1'b0;
          if (start_ok_d) begin
            state_q   <= S_SAMPLE;
            cnt_q     <= '0;
            bit_idx_q <= 4'd11;
            dac_q     <= '0;
            sample_q  <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_SAMPLE: begin
          if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
            state_q  <= S_SETTLE;
            cnt_q    <= '0;
            sample_q <= 1'b0;
            dac_q    <= 12'h800;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            state_q   <= S_STROBE;
            cnt_q     <= '0;
            comp_en_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STROBE: begin
          state_q   <= S_DECIDE;
          comp_en_q <= 1'b0;
        end
        S_DECIDE: begin
          if (bit_idx_q != 4'd0) begin
            state_q   <= S_SETTLE;
            bit_idx_q <= bit_idx_q - 4'd1;
            dac_q     <= code_d | (bit_mask_d >> 1);
          end else if (conv_last_d) begin
            state_q  <= S_DONE;
            dac_q    <= code_d;
            result_q <= result_d;
            valid_q  <= 1'b1;
          end else begin
            // Next averaged conversion starts its own sample phase without leaving busy.
            state_q   <= S_SAMPLE;
            cnt_q     <= '0;
            bit_idx_q <= 4'd11;
            dac_q     <= '0;
            sample_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dac_code_out = dac_q;
  assign sample_out   = sample_q;
  assign comp_en_out  = comp_en_q;
  assign busy_out     = busy_q;
  assign result_out   = result_q;
  assign valid_out    = valid_q;

endmodule

// File: tb/tb_adc_sar_controller.sv
// Self-checking bench for adc_sar_controller: table-driven conversions with an ideal comparator
// model, a result scoreboard, and hand sequences for ignored starts, abort, reset and averaging.
module tb_adc_sar_controller;

  localparam int SAMPLE_CYCLES = 2;
  localparam int SETTLE_CYCLES = 1;
  localparam int AVG_LOG2      = 2;
  localparam int LATENCY       = 1 + SAMPLE_CYCLES + 12 * (SETTLE_CYCLES + 2);

  logic        clk = 1'b0;
  logic        rst;
  logic        start_conv_in;
  logic        abort_in;
  logic        comp_in;
  logic [11:0] dac_code_out;
  logic        sample_out;
  logic        comp_en_out;
  logic        busy_out;
  logic [11:0] result_out;
  logic        valid_out;

  adc_sar_controller #(
    .SAMPLE_CYCLES(SAMPLE_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .AVG_LOG2     (AVG_LOG2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_conv_in(start_conv_in),
    .abort_in     (abort_in),
    .comp_in      (comp_in),
    .dac_code_out (dac_code_out),
    .sample_out   (sample_out),
    .comp_en_out  (comp_en_out),
    .busy_out     (busy_out),
    .result_out   (result_out),
    .valid_out    (valid_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Ideal comparator: answers only in the cycle after the strobe, X otherwise.
  logic        in_decide = 1'b0;
  int          comp_mode = 2;
  logic [11:0] vin = '0;
  logic        model_bit;
  always @(posedge clk) in_decide <= comp_en_out;
  always @* begin
    case (comp_mode)
      0:       model_bit = 1'b0;
      1:       model_bit = 1'b1;
      default: model_bit = (vin >= dac_code_out);
    endcase
    comp_in = in_decide ? model_bit : 1'bx;
  end

  typedef struct {
    logic [11:0] result;
    int          start_edge;
    int          exp_cycle;
  } exp_t;
  exp_t exp_q[$];

  int          valid_cnt  = 0;
  int          strobe_cnt = 0;
  int          sample_cnt = 0;
  logic [11:0] trials[12];

  always @(negedge clk) begin
    if (comp_en_out) begin
      if (strobe_cnt < 12) trials[strobe_cnt] = dac_code_out;
      strobe_cnt++;
    end
    if (sample_out) sample_cnt++;
    if (valid_out) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", 32'(result_out), 32'(e.result));
        if (e.exp_cycle > 0) check("latency", 32'(edge_cnt - e.start_edge + 1), 32'(e.exp_cycle));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (edge_cnt < n) step();
  endtask

  task automatic clear_counts();
    valid_cnt  = 0;
    strobe_cnt = 0;
    sample_cnt = 0;
  endtask

  task automatic do_start(input bit push, input logic [11:0] exp_res, input int exp_cycle);
    exp_t e;
    start_conv_in = 1'b1;
    if (push) begin
      e.result     = exp_res;
      e.start_edge = edge_cnt + 1;
      e.exp_cycle  = exp_cycle;
      exp_q.push_back(e);
    end
    step();
    start_conv_in = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    for (int c = 0; c < budget && valid_cnt == 0; c++) step();
    check("valid_seen_in_time", 32'(valid_cnt != 0), 32'd1);
  endtask

  typedef struct {
    int          mode;
    logic [11:0] vin;
    logic [11:0] exp;
  } vec_t;
  vec_t vecs[8];

  int          s;
  int          busy_drops;
  logic [11:0] prev_result;

  initial begin
    vecs[0] = '{2, 12'hA5C, 12'hA5C};
    vecs[1] = '{1, 12'h000, 12'hFFF};
    vecs[2] = '{0, 12'h000, 12'h000};
    vecs[3] = '{2, 12'h000, 12'h000};
    vecs[4] = '{2, 12'hFFF, 12'hFFF};
    vecs[5] = '{2, 12'h001, 12'h001};
    vecs[6] = '{2, 12'h800, 12'h800};
    vecs[7] = '{2, 12'h7FF, 12'h7FF};

    rst = 1'b1;
    start_conv_in = 1'b0;
    abort_in = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_dac", 32'(dac_code_out), 32'h0);
    check("rst_sample", 32'(sample_out), 32'h0);
    check("rst_comp_en", 32'(comp_en_out), 32'h0);
    check("rst_busy", 32'(busy_out), 32'h0);
    check("rst_result", 32'(result_out), 32'h0);
    check("rst_valid", 32'(valid_out), 32'h0);

`ifdef ADC_SAR_AVG_EN
    begin
      logic [11:0] avg_tab[4];
      avg_tab[0] = 12'h100;
      avg_tab[1] = 12'h101;
      avg_tab[2] = 12'h102;
      avg_tab[3] = 12'h104;
      comp_mode = 2;
      clear_counts();
      busy_drops = 0;
      do_start(1'b1, 12'h101, 0);
      for (int c = 0; c < 400 && valid_cnt == 0; c++) begin
        if (sample_out && sample_cnt / SAMPLE_CYCLES < 4) vin = avg_tab[sample_cnt / SAMPLE_CYCLES];
        if (!busy_out) busy_drops++;
        step();
      end
      check("avg_valid_seen", 32'(valid_cnt), 32'd1);
      check("avg_busy_held", 32'(busy_drops), 32'd0);
      check("avg_strobes", 32'(strobe_cnt), 32'd48);
      repeat (20) step();
      check("avg_single_valid", 32'(valid_cnt), 32'd1);
      check("avg_result_held", 32'(result_out), 32'h101);
    end
`else
    for (int i = 0; i < 8; i++) begin
      comp_mode = vecs[i].mode;
      vin = vecs[i].vin;
      clear_counts();
      do_start(1'b1, vecs[i].exp, LATENCY);
      check("busy_after_start", 32'(busy_out), 32'd1);
      wait_valid(200);
      check("busy_after_done", 32'(busy_out), 32'd0);
      check("strobe_count", 32'(strobe_cnt), 32'd12);
      check("sample_count", 32'(sample_cnt), 32'(SAMPLE_CYCLES));
      check("final_dac_code", 32'(dac_code_out), 32'(vecs[i].exp));
      repeat (5) step();
      check("one_valid", 32'(valid_cnt), 32'd1);
      if (i == 0) begin
        check("trial0", 32'(trials[0]), 32'h800);
        check("trial1", 32'(trials[1]), 32'hC00);
        check("trial2", 32'(trials[2]), 32'hA00);
      end
    end

    // Starts during a busy conversion (cycle 5 and the DONE cycle) are ignored.
    comp_mode = 2;
    vin = 12'h3C5;
    clear_counts();
    do_start(1'b1, 12'h3C5, LATENCY);
    s = edge_cnt;
    wait_until(s + 4);
    do_start(1'b0, 12'h000, 0);
    wait_until(s + LATENCY - 1);
    check("valid_in_done", 32'(valid_out), 32'd1);
    do_start(1'b0, 12'h000, 0);
    repeat (3) step();
    check("start_in_done_ignored", 32'(busy_out), 32'd0);
    repeat (60) step();
    check("ignored_one_valid", 32'(valid_cnt), 32'd1);
    check("ignored_samples", 32'(sample_cnt), 32'(SAMPLE_CYCLES));

    // Start and abort together in IDLE.
    clear_counts();
    start_conv_in = 1'b1;
    abort_in = 1'b1;
    step();
    start_conv_in = 1'b0;
    abort_in = 1'b0;
    check("start_abort_busy", 32'(busy_out), 32'd0);
    check("start_abort_sample", 32'(sample_out), 32'd0);
    repeat (50) step();
    check("start_abort_no_valid", 32'(valid_cnt), 32'd0);

    // Abort in DECIDE of bit 5.
    prev_result = 12'h3C5;
    vin = 12'h6B2;
    clear_counts();
    do_start(1'b0, 12'h000, 0);
    s = edge_cnt;
    wait_until(s + 22);
    check("trial_bit5", 32'(dac_code_out), 32'((12'h6B2 & 12'hFC0) | 12'h020));
    abort_in = 1'b1;
    step();
    abort_in = 1'b0;
    check("abort_busy", 32'(busy_out), 32'd0);
    check("abort_dac", 32'(dac_code_out), 32'h0);
    check("abort_sample", 32'(sample_out), 32'd0);
    check("abort_comp_en", 32'(comp_en_out), 32'd0);
    check("abort_result_kept", 32'(result_out), 32'(prev_result));
    repeat (50) step();
    check("abort_no_valid", 32'(valid_cnt), 32'd0);

    // Reset in the first SETTLE, then a clean conversion.
    vin = 12'h5A3;
    clear_counts();
    do_start(1'b0, 12'h000, 0);
    s = edge_cnt;
    wait_until(s + 2);
    check("settle_dac", 32'(dac_code_out), 32'h800);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_dac", 32'(dac_code_out), 32'h0);
    check("midrst_sample", 32'(sample_out), 32'h0);
    check("midrst_comp_en", 32'(comp_en_out), 32'h0);
    check("midrst_busy", 32'(busy_out), 32'h0);
    check("midrst_result", 32'(result_out), 32'h0);
    check("midrst_valid", 32'(valid_out), 32'h0);
    step();
    clear_counts();
    do_start(1'b1, 12'h5A3, LATENCY);
    wait_valid(200);
    repeat (3) step();
    check("post_rst_one_valid", 32'(valid_cnt), 32'd1);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_sar_controller.md
Name: adc_sar_controller

Overview:
- Successive-approximation sequencer for the 12-bit capacitive SAR ADC.
- Sits directly upstream of the row/column thermometer decoder and drives its 12-bit binary data input with the trial DAC code.
- Controls the sample switch, settle wait, comparator strobe and bit decisions, then delivers the final conversion result with a one-cycle valid pulse.

Parameters:
- SAMPLE_CYCLES, 2, cycles sample_out stays high per conversion; legal range ≥1.
- SETTLE_CYCLES, 1, cycles the DAC settles after each trial-bit update; legal range ≥1.
- AVG_LOG2, 2, log2 of the number of conversions averaged; used only with ADC_SAR_AVG_EN; legal range 0..4.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start_conv_in  in  1  conversion request; sampled only in IDLE.
- abort_in  in  1  cancels the conversion in progress.
- comp_in  in  1  comparator result; 1 = input above DAC, keep trial bit. Valid only in DECIDE.
- dac_code_out  out  12  trial/final code to the capacitor-matrix decoder ([11:8] row, [7:3] col, [2:0] bincap).
- sample_out  out  1  sample/track switch enable.
- comp_en_out  out  1  comparator strobe.
- busy_out  out  1  high in every state except IDLE.
- result_out  out  12  last completed result; held until the next completion.
- valid_out  out  1  one-cycle pulse when result_out updates.

Behaviour:
- Reset: all outputs 0; state IDLE; bit index 11.
- State sequence: IDLE -> SAMPLE -> SETTLE -> STROBE -> DECIDE -> (SETTLE | DONE) -> IDLE.
- IDLE: when start_conv_in=1 and abort_in=0, go to SAMPLE. dac_code_out is cleared to 0x000 on the same edge.
- SAMPLE: sample_out=1 for exactly SAMPLE_CYCLES cycles; dac_code_out=0x000.
- On the SAMPLE->SETTLE edge, dac_code_out[11] is set: first trial code 0x800.
- SETTLE: hold for SETTLE_CYCLES cycles, then go to STROBE.
- STROBE: comp_en_out=1 for exactly 1 cycle.
- DECIDE (1 cycle): comp_in is registered.
  - If comp_in=0, clear the current bit.
  - If bit index >0: decrement it, set the next lower bit in the same edge, go to SETTLE.
  - If bit index =0: go to DONE.
- DONE (1 cycle): result_out <= dac_code_out; valid_out=1; then IDLE. dac_code_out keeps the final code until the next start.
- Latency: if start is seen at edge 0, valid_out is high during cycle 1+SAMPLE_CYCLES+12*(SETTLE_CYCLES+2). Defaults give cycle 39.
- busy_out=1 from the cycle after start acceptance through DONE inclusive.
- start_conv_in outside IDLE (including DONE) is ignored; there is no queueing.
- abort_in in any non-IDLE state: next state is IDLE; dac_code_out=0; sample_out=0; comp_en_out=0. No valid_out; result_out unchanged.
- abort_in and start_conv_in together in IDLE: abort wins and the block stays IDLE.
- rst mid-conversion: identical to the reset state on the next edge; result_out is also cleared.
- comp_in outside DECIDE is ignored; X there must not propagate.

Optional Feature:
- Macro: ADC_SAR_AVG_EN.
- Defined: one start runs 2^AVG_LOG2 back-to-back full conversions, each with its own SAMPLE phase.
  - Each final code is added into a (12+AVG_LOG2)-bit accumulator, cleared at start.
  - result_out = accumulator >> AVG_LOG2 (truncating); one valid_out after the last conversion only.
  - busy_out stays high between conversions.
  - abort discards the accumulator.
- Undefined: single conversion per start; AVG_LOG2 is ignored; no accumulator logic is synthesized.

Test Plan:
- Ideal comparator model, Vin code 0xA5C, default parameters, start at edge 0 -> trial codes 0x800, 0xC00, 0xA00, ...; valid_out pulse at cycle 39; result_out=0xA5C; busy_out falls after DONE.
- comp_in tied 1 -> result 0xFFF; comp_in tied 0 -> result 0x000; comp_en_out pulses exactly 12 times per conversion.
- start_conv_in pulsed at cycles 5 and 39 (DONE) of a busy conversion -> both ignored, exactly one valid_out; start and abort together in IDLE -> stays IDLE.
- abort_in asserted in DECIDE of bit 5 -> IDLE next cycle; dac_code_out=0; no valid_out; previous result_out retained.
- rst asserted mid-SETTLE -> all outputs 0 next edge; a new start then yields the correct result with latency 39.
- ADC_SAR_AVG_EN, AVG_LOG2=2, model codes 0x100, 0x101, 0x102, 0x104 -> one valid_out after the fourth conversion; result_out=0x101.
